adsr_scan_ctrl: RTL
===================

# adsr_scan_ctrl

Time-multiplexing initiator for the 32-voice RAM-based ADSR envelope block. It walks the voice index, issues the single-clock `ena` strobe with a stable `sel` and per-voice `GATE`, and captures each voice's 18-bit envelope into a local envelope RAM. The tone-generator side reads that RAM by voice index. It sits between the voice allocator, which sends note on/off events, and the ADSR / tone-generator amplitude path.

## Interface
Parameters:
- `VOICES`, 32: number of voices scanned; must match the ADSR instance count.
- `SLOT_CLKS`, 4: clocks per voice slot; minimum 4 (the ADSR needs 3 clocks per service).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, 50 MHz
- `rst`  in  1  synchronous, active-high reset
- `gate_on`  in  1  one-clock pulse; note-on for `gate_voice`
- `gate_off`  in  1  one-clock pulse; note-off for `gate_voice`
- `gate_voice`  in  5  voice index for `gate_on`/`gate_off`
- `env_in`  in  18  ADSR `out`, signed
- `ena`  out  1  ADSR service strobe
- `sel`  out  5  ADSR voice select
- `GATE`  out  1  gate level presented to the ADSR for voice `sel`
- `rd_voice`  in  5  envelope read address
- `rd_env`  out  18  captured envelope for `rd_voice`, signed
- `gate_state`  out  32  current gate register, bit n = voice n
- `frame_done`  out  1  one-clock pulse after the capture of voice `VOICES-1`

## Operation
- Slot counter `slot` runs 0..SLOT_CLKS-1. Voice counter `vc` runs 0..VOICES-1 and wraps to 0. `vc` advances when `slot == SLOT_CLKS-1`.
- `ena` is 1 exactly in the cycles where `slot == 0`.
- `sel = vc`, registered. It is constant for the whole slot, because the ADSR writes its RAM at the third clock using `sel`.
- `GATE = gate_reg[vc] & ~retrig[vc]`, registered. It is constant for the whole slot.
- Gate register, updated per event:
  - `gate_off` clears `gate_reg[v]` and `retrig[v]`.
  - `gate_on` on a voice whose gate is clear sets `gate_reg[v]`.
  - `gate_on` on a voice whose gate is already set also sets `retrig[v]`. That voice is then presented `GATE=0` for one scan, which moves it to RELEASE. `retrig[v]` clears at the end of that voice's slot, and the next scan presents `GATE=1`, which gives ATTACK.
  - `gate_on` and `gate_off` in the same cycle: `gate_on` wins and the event is treated as a retrigger if the gate was set.
  - Events landing on the voice currently in its slot take effect from that voice's next slot. The registered `GATE` does not change mid-slot.
- Capture: when `slot == SLOT_CLKS-1`, write `env_in` to `env_ram[vc]`. `env_in` is valid from slot cycle 2 onward.
- `frame_done` pulses in the cycle after the capture of voice `VOICES-1`.
- Read port: `rd_env` is the registered value of `env_ram[rd_voice]`, with 1-clock latency. A read of the address being written in the same cycle returns the old value.

## Timing
- Reset values:
  - Outputs: `ena`=0, `sel`=0, `GATE`=0, `rd_env`=0, `gate_state`=0, `frame_done`=0.
  - Internal: `slot`=0, `vc`=0, all `gate_reg` and `retrig` bits = 0.
  - `env_ram` is not cleared. Its contents are undefined until the first `frame_done` after reset.
- First `ena` occurs in the first cycle after `rst` deasserts, with `sel`=0.
- Reset mid-slot aborts the scan. Voices whose ADSR was active are driven to RELEASE, then IDLE, on later scans, because every `GATE` is 0 after reset.
- Event-to-`GATE` latency: a pulse at cycle t affects the next slot of that voice whose `slot==0` cycle is later than t+1 (worst case one full frame).
- Frame period is `VOICES*SLOT_CLKS` = 128 clocks, giving a 390.625 kHz per-voice update at 50 MHz.
- `gate_state` is updated 1 clock after the event.

## Test plan
- Reset, then run 300 clocks → `ena` pulses every 4 clocks; `sel` steps 0,1,…,31,0; `GATE`=0 throughout; `frame_done` pulses at clocks 128 and 256 after reset release.
- `gate_on`, `gate_voice`=5 at clock 10 → `gate_state`=0x20 at clock 11; `GATE`=1 during every slot with `sel`=5 from the first such slot after clock 11.
- Voice 5 gate already set, `gate_on` voice 5 again → next voice-5 slot `GATE`=0, the following one `GATE`=1; `gate_state` bit 5 stays 1.
- `gate_on` and `gate_off` together on voice 9 with its gate clear → bit 9 set, no retrigger slot; with its gate set → one `GATE`=0 slot, then `GATE`=1.
- Model ADSR drives `env_in` = 0x100+sel from slot cycle 2 → after `frame_done`, reading `rd_voice`=n returns 0x100+n one clock later, for all n.
- Assert `rst` at slot 2 of voice 17 with gates set → all outputs reach reset values on the next clock; the scan restarts at `sel`=0 with `GATE`=0 for all voices.

Source files
------------

// File: rtl/adsr_scan_ctrl_if.sv
// Service port between the scan controller and the time-multiplexed ADSR block:
// the controller strobes ena with a stable sel/GATE and receives the envelope back.
interface adsr_scan_ctrl_if;
  logic               ena;
  logic        [4:0]  sel;
  logic               GATE;
  logic signed [17:0] env_in;

  modport master (output ena, output sel, output GATE, input env_in);
  modport slave  (input ena, input sel, input GATE, output env_in);
endinterface

// File: rtl/adsr_scan_ctrl.sv
// Voice scanner for the shared ADSR: walks voices slot by slot, presents each voice's gate,
// and keeps a local RAM of the latest envelope per voice for the tone generator.
module adsr_scan_ctrl #(
  parameter int VOICES    = 32,
  parameter int SLOT_CLKS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                gate_on,
  input  logic                gate_off,
  input  logic        [4:0]   gate_voice,
  adsr_scan_ctrl_if.master    adsr,
  input  logic        [4:0]   rd_voice,
  output logic signed [17:0]  rd_env,
  output logic        [31:0]  gate_state,
  output logic                frame_done
);

  localparam int             SW         = (SLOT_CLKS > 1) ? $clog2(SLOT_CLKS) : 1;
  localparam logic [SW-1:0]  LAST_SLOT  = SW'(SLOT_CLKS - 1);
  localparam logic [4:0]     LAST_VOICE = 5'(VOICES - 1);

  logic [SW-1:0]      slot;
  logic [4:0]         vc;
  logic [4:0]         vc_next;
  logic               slot_end;
  logic               gate_q;
  logic               retrig_shown;
  logic [31:0]        gate_reg;
  logic [31:0]        retrig;
  logic [31:0]        gate_nxt;
  logic [31:0]        retrig_nxt;
  logic signed [17:0] env_ram [VOICES];

  assign slot_end = (slot == LAST_SLOT);
  assign vc_next  = (vc == LAST_VOICE) ? 5'd0 : vc + 5'd1;

  // ena is gated by rst so it is already low while reset is held and high in the first free cycle
  assign adsr.ena   = (slot == '0) && !rst;
  assign adsr.sel   = vc;
  assign adsr.GATE  = gate_q;
  assign gate_state = gate_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot         <= '0;
      vc           <= 5'd0;
      gate_q       <= 1'b0;
      retrig_shown <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= slot_end && (vc == LAST_VOICE);
      if (slot_end) begin
        slot         <= '0;
        vc           <= vc_next;
        gate_q       <= gate_reg[vc_next] & ~retrig[vc_next];
        retrig_shown <= retrig[vc_next];
      end else begin
        slot <= slot + 1'b1;
      end
    end
  end

  // A retrigger is only retired once its GATE=0 slot has actually been presented;
  // a retrigger raised mid-slot survives to the voice's next slot.
  always_comb begin
    gate_nxt   = gate_reg;
    retrig_nxt = retrig;
    if (slot_end && retrig_shown) begin
      retrig_nxt[vc] = 1'b0;
    end
    if (gate_on) begin
      if (gate_reg[gate_voice]) begin
        retrig_nxt[gate_voice] = 1'b1;
      end
      gate_nxt[gate_voice] = 1'b1;
    end else if (gate_off) begin
      gate_nxt[gate_voice]   = 1'b0;
      retrig_nxt[gate_voice] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gate_reg <= 32'd0;
      retrig   <= 32'd0;
    end else begin
      gate_reg <= gate_nxt;
      retrig   <= retrig_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && slot_end) begin
      env_ram[vc] <= adsr.env_in;
    end
  end

  // Registered read; a same-cycle write to the same address is seen one read later
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_env <= 18'sd0;
    end else begin
      rd_env <= env_ram[rd_voice];
    end
  end

endmodule
